// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename busy/tag tracking and commit bypass
module reg_file #(
  parameter int VAL_WIDTH = 32,
  parameter int ID_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_en,
  input  logic [4:0]           issue_rd,
  input  logic [ID_WIDTH-1:0]  issue_tag,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [VAL_WIDTH-1:0] rs1_val,
  output logic                 rs1_busy,
  output logic [ID_WIDTH-1:0]  rs1_tag,
  output logic [VAL_WIDTH-1:0] rs2_val,
  output logic                 rs2_busy,
  output logic [ID_WIDTH-1:0]  rs2_tag,
  input  logic                 commit_en,
  input  logic [4:0]           commit_rd,
  input  logic [ID_WIDTH-1:0]  commit_tag,
  input  logic [VAL_WIDTH-1:0] commit_val,
  input  logic                 flush,
  output logic [5:0]           busy_count
);

  logic [VAL_WIDTH-1:0] value_q [32];
  logic [ID_WIDTH-1:0]  tag_q   [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_next;
  logic [5:0]           count_next;

  logic do_issue;
  logic do_commit;
  logic do_flush;
  logic commit_clear;

  // Qualified events; x0 is never a rename or commit target.
  assign do_flush     = rdy_in & flush;
  assign do_issue     = rdy_in & issue_en & (issue_rd != 5'd0) & ~flush;
  assign do_commit    = rdy_in & commit_en & (commit_rd != 5'd0);
  assign commit_clear = do_commit & busy_q[commit_rd] & (tag_q[commit_rd] == commit_tag)
                        & ~(do_issue & (issue_rd == commit_rd));

  // Next busy vector: flush wins, otherwise a matching commit clears and an issue sets.
  always_comb begin
    busy_next = busy_q;
    if (do_flush) begin
      busy_next = '0;
    end else begin
      if (commit_clear) busy_next[commit_rd] = 1'b0;
      if (do_issue)     busy_next[issue_rd]  = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Popcount of the next busy vector so busy_count tracks state after each edge.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < 32; i++) begin
      count_next = count_next + 6'(busy_next[i]);
    end
  end

  // State update: values on commit, tags on issue, busy bits and count from next-state logic.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
    end else if (rdy_in) begin
      if (do_commit) value_q[commit_rd] <= commit_val;
      if (do_issue)  tag_q[issue_rd]    <= issue_tag;
      busy_q     <= busy_next;
      busy_count <= count_next;
    end
  end

  // rs1 read port with same-cycle commit bypass on a tag match.
  always_comb begin
    logic byp;
    byp = do_commit & (commit_rd == rs1) & busy_q[rs1] & (commit_tag == tag_q[rs1]);
    if (rs1 == 5'd0) begin
      rs1_val  = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end else begin
      rs1_val  = byp ? commit_val : value_q[rs1];
      rs1_busy = busy_q[rs1] & ~byp;
      rs1_tag  = tag_q[rs1];
    end
  end

  // rs2 read port with same-cycle commit bypass on a tag match.
  always_comb begin
    logic byp;
    byp = do_commit & (commit_rd == rs2) & busy_q[rs2] & (commit_tag == tag_q[rs2]);
    if (rs2 == 5'd0) begin
      rs2_val  = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end else begin
      rs2_val  = byp ? commit_val : value_q[rs2];
      rs2_busy = busy_q[rs2] & ~byp;
      rs2_tag  = tag_q[rs2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed self-checking bench for reg_file
module tb_reg_file;

  localparam int VW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          issue_en;
  logic [4:0]    issue_rd;
  logic [IW-1:0] issue_tag;
  logic [4:0]    rs1, rs2;
  logic [VW-1:0] rs1_val, rs2_val;
  logic          rs1_busy, rs2_busy;
  logic [IW-1:0] rs1_tag, rs2_tag;
  logic          commit_en;
  logic [4:0]    commit_rd;
  logic [IW-1:0] commit_tag;
  logic [VW-1:0] commit_val;
  logic          flush;
  logic [5:0]    busy_count;

  reg_file #(.VAL_WIDTH(VW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .flush(flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference architectural state
  logic [VW-1:0] m_val  [32];
  logic [IW-1:0] m_tag  [32];
  bit            m_busy [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_read(input logic [4:0] r, output logic [VW-1:0] v,
                            output logic b, output logic [IW-1:0] t);
    bit hit;
    if (r == 0) begin
      v = '0; b = 1'b0; t = '0;
    end else begin
      hit = rdy_in && commit_en && commit_rd == r && m_busy[r] && commit_tag == m_tag[r];
      v = hit ? commit_val : m_val[r];
      b = m_busy[r] && !hit;
      t = m_tag[r];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_tag[i] = '0; m_busy[i] = 1'b0;
    end
  endtask

  // Apply the effect of the upcoming rising edge to the model.
  task automatic model_step();
    bit issue_ok;
    if (!rdy_in) return;
    issue_ok = issue_en && issue_rd != 0 && !flush;
    if (commit_en && commit_rd != 0) begin
      m_val[commit_rd] = commit_val;
      if (m_busy[commit_rd] && m_tag[commit_rd] == commit_tag &&
          !(issue_ok && issue_rd == commit_rd))
        m_busy[commit_rd] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (issue_ok) begin
      m_busy[issue_rd] = 1'b1;
      m_tag[issue_rd]  = issue_tag;
    end
  endtask

  // Compare every cycle at the falling edge, then advance the model.
  initial begin
    logic [VW-1:0] ev;
    logic          eb;
    logic [IW-1:0] et;
    forever begin
      @(negedge clk);
      if (!rst_in) model_reset();
      model_read(rs1, ev, eb, et);
      check("rs1_val", rs1_val, ev);
      check("rs1_busy", 32'(rs1_busy), 32'(eb));
      check("rs1_tag", 32'(rs1_tag), 32'(et));
      model_read(rs2, ev, eb, et);
      check("rs2_val", rs2_val, ev);
      check("rs2_busy", 32'(rs2_busy), 32'(eb));
      check("rs2_tag", 32'(rs2_tag), 32'(et));
      check("busy_count", 32'(busy_count), 32'(model_count()));
      if (rst_in) model_step();
    end
  end

  task automatic idle();
    issue_en = 0; issue_rd = 0; issue_tag = 0;
    commit_en = 0; commit_rd = 0; commit_tag = 0; commit_val = 0;
    flush = 0; rdy_in = 1;
  endtask

  // Advance to just after the next rising edge, where inputs get driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [IW-1:0] t);
    issue_en = 1; issue_rd = rd; issue_tag = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [IW-1:0] t, input logic [VW-1:0] v);
    commit_en = 1; commit_rd = rd; commit_tag = t; commit_val = v;
  endtask

  initial begin
    rst_in = 0; rs1 = 0; rs2 = 0;
    idle();
    step(); step();
    #2;
    check("reset_busy_count", 32'(busy_count), 32'd0);
    rs1 = 5; #1;
    check("reset_rs1_val", rs1_val, 32'd0);
    check("reset_rs1_busy", 32'(rs1_busy), 32'd0);
    step();
    rst_in = 1;

    // Rename then read
    step(); idle(); issue(5, 3);
    step(); idle(); rs1 = 5; #2;
    check("d032_busy", 32'(rs1_busy), 32'd1);
    check("d032_tag", 32'(rs1_tag), 32'd3);
    check("d032_count", 32'(busy_count), 32'd1);

    // Bypass on matching commit
    step(); idle(); commit(5, 3, 32'hDEADBEEF); #2;
    check("d033_bypass_val", rs1_val, 32'hDEADBEEF);
    check("d033_bypass_busy", 32'(rs1_busy), 32'd0);
    step(); idle(); #2;
    check("d033_count", 32'(busy_count), 32'd0);

    // Stale-tag commit writes value but leaves newer rename busy
    step(); idle(); issue(5, 3);
    step(); idle(); issue(5, 7);
    step(); idle(); commit(5, 3, 32'h11); #2;
    check("d034_no_bypass", rs1_val, 32'hDEADBEEF);
    step(); idle(); #2;
    check("d034_val", rs1_val, 32'h11);
    check("d034_busy", 32'(rs1_busy), 32'd1);
    check("d034_tag", 32'(rs1_tag), 32'd7);
    check("d034_model_val", m_val[5], 32'h11);
    check("d034_model_tag", 32'(m_tag[5]), 32'd7);

    // Same-cycle commit and issue to one register
    step(); idle(); commit(6, 2, 32'h22); issue(6, 9); rs2 = 6;
    step(); idle(); #2;
    check("d035_val", rs2_val, 32'h22);
    check("d035_busy", 32'(rs2_busy), 32'd1);
    check("d035_tag", 32'(rs2_tag), 32'd9);
    check("d035_count", 32'(busy_count), 32'd2);

    // Flush drops all renames and ignores same-cycle issue
    for (int r = 1; r <= 4; r++) begin
      step(); idle(); issue(5'(r), 4'(r));
    end
    step(); idle(); #2;
    check("d036_pre_count", 32'(busy_count), 32'd6);
    step(); idle(); flush = 1; issue(8, 5);
    step(); idle(); rs1 = 8; #2;
    check("d036_busy", 32'(rs1_busy), 32'd0);
    check("d036_count", 32'(busy_count), 32'd0);
    check("d036_model_count", 32'(model_count()), 32'd0);

    // x0 immune; rdy_in low freezes state
    step(); idle(); issue(0, 4); commit(0, 4, 32'h55); rs1 = 0;
    step(); idle(); #2;
    check("d037_x0_val", rs1_val, 32'd0);
    check("d037_x0_busy", 32'(rs1_busy), 32'd0);
    check("d037_x0_tag", 32'(rs1_tag), 32'd0);
    step(); idle(); rdy_in = 0; issue(9, 1);
    step(); idle(); rs1 = 9; #2;
    check("d037_rdy_busy", 32'(rs1_busy), 32'd0);
    check("d037_rdy_count", 32'(busy_count), 32'd0);

    // Mid-operation reset abandons renames; next issue works
    step(); idle(); issue(10, 2);
    step(); idle(); rst_in = 0; rs1 = 10; #2;
    check("rst_mid_busy", 32'(rs1_busy), 32'd0);
    check("rst_mid_count", 32'(busy_count), 32'd0);
    step(); rst_in = 1; idle(); issue(10, 6);
    step(); idle(); #2;
    check("rst_after_busy", 32'(rs1_busy), 32'd1);
    check("rst_after_tag", 32'(rs1_tag), 32'd6);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] crd;
      step(); idle();
      if ($urandom_range(0, 199) == 0) rst_in = 0; else rst_in = 1;
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        issue_en  = 1;
        issue_rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        issue_tag = 4'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        crd = 5'($urandom_range(0, 7));
        commit_en  = 1;
        commit_rd  = crd;
        commit_tag = ($urandom_range(0, 3) != 0) ? m_tag[crd] : 4'($urandom);
        commit_val = $urandom;
      end
      flush = ($urandom_range(0, 29) == 0);
      rs1 = ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom_range(0, 9));
      rs2 = 5'($urandom_range(0, 31));
    end

    step(); idle(); rst_in = 1;
    step();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter VAL_WIDTH, default 32, data width of each architectural register.
REQ-002 SHALL have parameter ID_WIDTH, default 4, ROB tag width (16 ROB entries).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; when low, no state changes.
REQ-006 SHALL have port issue_en  input  1  rename request from issue.
REQ-007 SHALL have port issue_rd  input  5  destination register being renamed.
REQ-008 SHALL have port issue_tag  input  ID_WIDTH  ROB tag assigned to issue_rd.
REQ-009 SHALL have port rs1  input  5  first source register index.
REQ-010 SHALL have port rs2  input  5  second source register index.
REQ-011 SHALL have port rs1_val  output  VAL_WIDTH  committed value of rs1, bypassed.
REQ-012 SHALL have port rs1_busy  output  1  rs1 awaits an in-flight producer.
REQ-013 SHALL have port rs1_tag  output  ID_WIDTH  producer tag of rs1, valid when rs1_busy=1.
REQ-014 SHALL have ports rs2_val, rs2_busy, rs2_tag, same widths and meaning for rs2.
REQ-015 SHALL have port commit_en  input  1  ROB commits a register result.
REQ-016 SHALL have port commit_rd  input  5  committed destination.
REQ-017 SHALL have port commit_tag  input  ID_WIDTH  tag of the committing entry.
REQ-018 SHALL have port commit_val  input  VAL_WIDTH  committed value.
REQ-019 SHALL have port flush  input  1  misprediction flush from ROB.
REQ-020 SHALL have port busy_count  output  6  number of registers currently busy (0..31).

Function
REQ-021 SHALL hold 32 value registers, 32 busy bits, 32 tag fields; x0 reads value 0, busy 0, tag 0 always, and is never written or renamed.
REQ-022 SHALL produce rs*_val/busy/tag combinationally from current state, reflecting the pre-issue state (same-cycle issue to the same register does not affect the read).
REQ-023 SHALL bypass: if commit_en=1, commit_rd=rsN!=0, busy[rsN]=1 and commit_tag=tag[rsN], then rsN_val=commit_val and rsN_busy=0.
REQ-024 SHALL on commit (commit_en=1, commit_rd!=0) write commit_val to value[commit_rd] next edge regardless of tag match.
REQ-025 SHALL clear busy[commit_rd] on commit only when commit_tag equals the stored tag and no same-cycle issue targets commit_rd.
REQ-026 SHALL on issue (issue_en=1, issue_rd!=0, flush=0) set busy[issue_rd]=1 and tag[issue_rd]=issue_tag next edge, overriding any same-cycle commit clear.
REQ-027 SHALL on flush=1 clear all busy bits next edge, ignore issue, but still apply a same-cycle commit value write.
REQ-028 SHALL update busy_count registered so it equals the popcount of busy bits after each edge; set and clear of the same register in one cycle nets to its final state.
REQ-029 SHALL ignore issue_en, commit_en and flush while rdy_in=0.

Reset
REQ-030 SHALL on rst_in=0 asynchronously clear all values, busy bits, tags and busy_count to 0; all outputs read 0 during and after reset until an update.
REQ-031 SHALL treat reset asserted mid-operation as abandoning all pending renames; first post-reset issue proceeds normally.

Verification
REQ-032 Issue x5 tag 3, next cycle read rs1=5 -> rs1_busy=1, rs1_tag=3, busy_count=1.
REQ-033 Commit x5 tag 3 val 0xDEADBEEF while reading rs1=5 -> same cycle rs1_val=0xDEADBEEF, rs1_busy=0; next cycle busy_count=0.
REQ-034 Issue x5 tag 3, issue x5 tag 7, commit x5 tag 3 val 0x11 -> value[5]=0x11, x5 stays busy with tag 7.
REQ-035 Same-cycle commit x6 tag 2 val 0x22 and issue x6 tag 9 -> next cycle x6 value 0x22, busy 1, tag 9.
REQ-036 Rename x1..x4, assert flush with issue x8 tag 5 -> all busy 0, x8 not busy, busy_count=0.
REQ-037 Issue x0 tag 4 and commit x0 val 0x55 -> x0 reads value 0, busy 0; rdy_in=0 with issue x9 -> no change.
